// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the shared iterative multiply/divide datapath.
// Issues load/step/fixup strobes, counts iterations, and reports completion and exceptions.
module multdiv_ctrl #(
  parameter int ITERS = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             mult_overflow,
  output logic             load,
  output logic             step,
  output logic             fixup,
  output logic             op_is_div,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIXUP, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             exc_r, exc_nx, div_nx;
  logic             start;

  assign start = ctrl_MULT | ctrl_DIV;

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    exc_nx   = exc_r;
    div_nx   = op_is_div;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD: begin
        if (op_is_div && divisor_zero) begin
          state_nx = DONE;
          exc_nx   = 1'b1;
        end else begin
          state_nx = RUN;
          exc_nx   = 1'b0;
        end
      end
      RUN: begin
        if (count == LAST) state_nx = op_is_div ? FIXUP : DONE;
        else               cnt_nx   = count + 1'b1;
      end
      FIXUP: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Any start restarts from LOAD: aborts an in-flight op, or chains straight out of DONE.
    if (start) begin
      state_nx = LOAD;
      cnt_nx   = '0;
      div_nx   = ctrl_DIV & ~ctrl_MULT;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state     <= IDLE;
      count     <= '0;
      op_is_div <= 1'b0;
      exc_r     <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= cnt_nx;
      op_is_div <= div_nx;
      exc_r     <= exc_nx;
    end
  end

  assign load           = (state == LOAD);
  assign step           = (state == RUN);
  assign fixup          = (state == FIXUP);
  assign busy           = (state != IDLE);
  assign data_resultRDY = (state == DONE);
  // Overflow only matters for multiplies; divide-by-zero arrives via exc_r.
  assign data_exception = data_resultRDY & (exc_r | (~op_is_div & mult_overflow));

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the driver predicts completion cycle and exception
// per start from the latency rules; a negedge monitor pops and compares on data_resultRDY.
module tb_multdiv_ctrl;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  logic clock = 1'b0, clr = 1'b1;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, divisor_zero = 1'b0, mult_overflow = 1'b0;
  logic load, step, fixup, op_is_div, busy, data_resultRDY, data_exception;
  logic [CNT_W-1:0] count;

  multdiv_ctrl #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
    .clock(clock), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .divisor_zero(divisor_zero), .mult_overflow(mult_overflow),
    .load(load), .step(step), .fixup(fixup), .op_is_div(op_is_div), .count(count),
    .busy(busy), .data_resultRDY(data_resultRDY), .data_exception(data_exception)
  );

  always #5 clock = ~clock;

  typedef struct {int cyc; bit exc; bit div;} exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   total = 0, bad = 0;
  bit   mon_en = 0, last_div = 0, prev_step = 0;
  int   prev_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Drive one start pulse, then set the operand flags for that op during its LOAD cycle.
  task automatic issue(input bit m, input bit d, input bit dz, input bit ov, input int gap);
    int  s, lat;
    bit  isdiv;
    @(posedge clock); #1;
    ctrl_MULT = m; ctrl_DIV = d;
    s     = cyc;
    isdiv = d & ~m;
    lat   = !isdiv ? ITERS + 2 : (dz ? 2 : ITERS + 3);
    if (sb.size() > 0 && sb[$].cyc > s) void'(sb.pop_back());
    sb.push_back('{cyc: s + lat, exc: isdiv ? dz : ov, div: isdiv});
    last_div = isdiv;
    @(posedge clock); #1;
    ctrl_MULT = 0; ctrl_DIV = 0;
    divisor_zero = dz; mult_overflow = ov;
    repeat (gap) @(posedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      exp_t e;
      chk("onehot", int'(load) + int'(step) + int'(fixup) + int'(data_resultRDY), busy ? 1 : 0);
      if (!step)          chk("count_outside_run", int'(count), 0);
      else if (prev_step) chk("count_inc", int'(count), prev_cnt + 1);
      else                chk("count_first", int'(count), 0);
      if (step && int'(count) > ITERS - 1) chk("count_max", int'(count), ITERS - 1);
      if (!ctrl_MULT && !ctrl_DIV) chk("op_is_div", int'(op_is_div), int'(last_div));
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missed_rdy", 0, e.cyc);
      end
      if (data_resultRDY) begin
        if (sb.size() == 0) chk("spurious_rdy", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rdy_cycle", cyc, e.cyc);
          chk("exception", int'(data_exception), int'(e.exc));
          chk("rdy_op_is_div", int'(op_is_div), int'(e.div));
        end
      end
      prev_step = step;
      prev_cnt  = int'(count);
    end
  end

  initial begin
    int n;
    // Reset held 3 cycles with a toggling multiply start.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      ctrl_MULT = ~ctrl_MULT;
      @(negedge clock);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_rdy", int'(data_resultRDY), 0);
    end
    @(posedge clock); #1;
    clr = 0; ctrl_MULT = 0;
    @(negedge clock);
    chk("post_rst_idle", {int'(busy), int'(load), int'(step), int'(fixup), int'(op_is_div)} == 0 ? 0 : 1, 0);
    mon_en = 1;

    issue(1, 0, 0, 0, 40);   // plain multiply
    issue(0, 1, 0, 1, 40);   // divide with fixup; overflow must not matter
    issue(0, 1, 1, 0, 5);    // divide by zero
    issue(1, 0, 0, 1, 7);    // multiply aborted by the divide below
    issue(0, 1, 0, 1, 40);
    issue(1, 1, 0, 0, 40);   // both starts: multiply wins
    issue(1, 0, 0, 1, 32);   // overflow; next start lands in DONE
    issue(0, 1, 0, 0, 33);   // divide; next start lands in DONE
    issue(0, 1, 1, 0, 0);    // divide by zero; next start lands in DONE
    issue(1, 0, 0, 0, 40);

    for (int i = 0; i < 40; i++) begin
      bit m, d;
      m = $urandom_range(0, 1);
      d = m ? bit'($urandom_range(0, 1)) : 1'b1;
      issue(m, d, $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0 ? $urandom_range(0, 34) : 40);
    end

    // Reset mid-run with a coinciding start: reset wins, nothing completes.
    issue(1, 0, 0, 0, 5);
    @(posedge clock); #1;
    clr = 1; ctrl_DIV = 1;
    @(posedge clock); #1;
    clr = 0; ctrl_DIV = 0;
    sb.delete();
    last_div = 0;
    @(negedge clock);
    chk("clr_wins_busy", int'(busy), 0);
    chk("clr_wins_op", int'(op_is_div), 0);
    repeat (40) @(posedge clock);

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
